// File: rtl/ldpc_wb_stream_bridge_if.sv
// rtl/ldpc_wb_stream_bridge_if.sv - Wishbone slave and core stream bundle for the LDPC bridge
// Purpose: groups the Wishbone classic slave signals, the tx/rx word streams
//          to and from ldpcEncDec, and the level interrupt.
// Modports:
//   slave  - the bridge: samples wbs_* requests, drives ack/read data,
//            sources tx_*, sinks rx_*, drives irq_o.
//   master - the surroundings (management SoC plus core): the mirror image.
interface ldpc_wb_stream_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        irq_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output tx_data_o, tx_valid_o,
    input  tx_ready_i,
    input  rx_data_i, rx_valid_i,
    output rx_ready_o,
    output irq_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  tx_data_o, tx_valid_o,
    output tx_ready_i,
    output rx_data_i, rx_valid_i,
    input  rx_ready_o,
    input  irq_o
  );
endinterface

// File: rtl/ldpc_wb_stream_bridge.sv
// rtl/ldpc_wb_stream_bridge.sv - Wishbone register front end streaming words to/from the LDPC core
// Purpose: software pushes words into an input FIFO (TXDATA), the bridge streams
//          them to the core, captures the core's results into an output FIFO
//          and lets software pop them (RXDATA). Sticky ovf/udf errors and a
//          level interrupt report results and misuse.
// Ports:
//   wb_clk_i  - single clock
//   wb_rst_ni - asynchronous active-low reset
//   bus       - slave side of ldpc_wb_stream_bridge_if (Wishbone, tx/rx streams, irq)
// Parameter: DEPTH - words per FIFO, power of two in 2..128.
module ldpc_wb_stream_bridge #(
  parameter int DEPTH = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  ldpc_wb_stream_bridge_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_TXDATA = 3'd2;
  localparam logic [2:0] A_RXDATA = 3'd3;

  logic [31:0]   in_mem  [DEPTH];
  logic [31:0]   out_mem [DEPTH];
  logic [PW-1:0] in_rd_q, in_wr_q, out_rd_q, out_wr_q;
  logic [PW-1:0] in_rd_d, in_wr_d, out_rd_d, out_wr_d;
  logic [CW-1:0] in_cnt_q, out_cnt_q, in_cnt_d, out_cnt_d;
  logic          enable_q, irq_en_q, ovf_q, udf_q, ack_q, irq_q;
  logic          enable_d, irq_en_d, ovf_d, udf_d, irq_d;
  logic [31:0]   dat_q, dat_d, rdata;

  logic [2:0] adr;
  logic       req, wr_ctrl, flush, wr_stat, tx_wr, rx_rd;
  logic       in_full, in_empty, out_full, out_empty;
  logic       in_push, in_pop, out_push, out_pop;
  logic       unused_ok;

  assign adr       = bus.wbs_adr_i[4:2];
  assign req       = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
  assign wr_ctrl   = req & bus.wbs_we_i & (adr == A_CTRL) & bus.wbs_sel_i[0];
  assign flush     = wr_ctrl & bus.wbs_dat_i[2];
  assign wr_stat   = req & bus.wbs_we_i & (adr == A_STATUS) & bus.wbs_sel_i[2];
  assign tx_wr     = req & bus.wbs_we_i & (adr == A_TXDATA);
  assign rx_rd     = req & ~bus.wbs_we_i & (adr == A_RXDATA);

  assign in_full   = (in_cnt_q == FULL_CNT);
  assign in_empty  = (in_cnt_q == '0);
  assign out_full  = (out_cnt_q == FULL_CNT);
  assign out_empty = (out_cnt_q == '0);

  assign bus.tx_valid_o = enable_q & ~in_empty;
  assign bus.tx_data_o  = in_mem[in_rd_q];
  assign bus.rx_ready_o = enable_q & ~out_full;
  assign bus.wbs_ack_o  = ack_q;
  assign bus.wbs_dat_o  = dat_q;
  assign bus.irq_o      = irq_q;

  // Fullness/emptiness are judged on the pre-edge counts, so a push into a
  // full FIFO is rejected even when the same edge pops a word.
  assign in_push  = tx_wr & ~in_full;
  assign in_pop   = bus.tx_valid_o & bus.tx_ready_i;
  assign out_push = bus.rx_valid_i & bus.rx_ready_o;
  assign out_pop  = rx_rd & ~out_empty;

  always_comb begin
    rdata = '0;
    case (adr)
      A_CTRL:   rdata = {30'd0, irq_en_q, enable_q};
      A_STATUS: rdata = {12'd0, udf_q, ovf_q, out_empty, in_full,
                         8'(out_cnt_q), 8'(in_cnt_q)};
      A_RXDATA: rdata = out_empty ? 32'd0 : out_mem[out_rd_q];
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    in_rd_d   = in_rd_q  + PW'(in_pop);
    in_wr_d   = in_wr_q  + PW'(in_push);
    out_rd_d  = out_rd_q + PW'(out_pop);
    out_wr_d  = out_wr_q + PW'(out_push);
    in_cnt_d  = in_cnt_q  + CW'(in_push)  - CW'(in_pop);
    out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
    ovf_d     = (ovf_q & ~(wr_stat & bus.wbs_dat_i[18])) | (tx_wr & in_full);
    udf_d     = (udf_q & ~(wr_stat & bus.wbs_dat_i[19])) | (rx_rd & out_empty);
    dat_d     = (req & ~bus.wbs_we_i) ? rdata : 32'd0;
    if (wr_ctrl) begin
      enable_d = bus.wbs_dat_i[0];
      irq_en_d = bus.wbs_dat_i[1];
    end
    // Flush overrides every stream or bus transfer landing on the same edge.
    if (flush) begin
      in_rd_d   = '0;
      in_wr_d   = '0;
      out_rd_d  = '0;
      out_wr_d  = '0;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
    irq_d = irq_en_d & ((out_cnt_d != '0) | ovf_d | udf_d);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
      dat_q     <= '0;
      in_rd_q   <= '0;
      in_wr_q   <= '0;
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      enable_q  <= enable_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      ack_q     <= req;
      irq_q     <= irq_d;
      dat_q     <= dat_d;
      in_rd_q   <= in_rd_d;
      in_wr_q   <= in_wr_d;
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Storage carries no reset; only the pointers and counts define contents.
  always_ff @(posedge wb_clk_i) begin
    if (in_push)  in_mem[in_wr_q]   <= bus.wbs_dat_i;
    if (out_push) out_mem[out_wr_q] <= bus.rx_data_i;
  end

  assign unused_ok = ^{bus.wbs_adr_i[31:5], bus.wbs_adr_i[1:0],
                       bus.wbs_sel_i[3], bus.wbs_sel_i[1]};
endmodule

// File: tb/tb_ldpc_wb_stream_bridge.sv
// tb/tb_ldpc_wb_stream_bridge.sv - Self-checking bench for ldpc_wb_stream_bridge
module tb_ldpc_wb_stream_bridge;
  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  ldpc_wb_stream_bridge_if bus ();

  ldpc_wb_stream_bridge #(.DEPTH(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Core model: 0 idle, 1 echo with random handshakes, 2 sink, 3 random source.
  int          mode = 0;
  logic [31:0] core_q[$];
  logic [31:0] cap_q[$];
  time         cap_t[$];
  logic [31:0] sent_q[$];
  bit          irq_watch = 0;
  bit          irq_due   = 0;

  always begin
    @(posedge clk);
    #3;
    if (irq_due) begin
      check_eq("irq_after_first_rx", 32'(bus.irq_o), 32'd1);
      irq_due = 0;
    end
    case (mode)
      1: begin
        bus.rx_valid_i = (core_q.size() > 0) && ($urandom_range(1) == 1);
        bus.rx_data_i  = bus.rx_valid_i ? core_q[0] : $urandom;
        bus.tx_ready_i = ($urandom_range(1) == 1);
      end
      2: begin
        bus.rx_valid_i = 1'b0;
        bus.tx_ready_i = 1'b1;
      end
      3: begin
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = $urandom;
        bus.tx_ready_i = 1'b0;
      end
      default: begin
        bus.rx_valid_i = 1'b0;
        bus.tx_ready_i = 1'b0;
      end
    endcase
    // Handshakes decided here complete on the next rising edge.
    if (bus.rx_valid_i && bus.rx_ready_o) begin
      cap_q.push_back(bus.rx_data_i);
      cap_t.push_back($time + 7);
      if (mode == 1) void'(core_q.pop_front());
      if (irq_watch) begin
        irq_watch = 0;
        irq_due   = 1;
      end
    end
    if (bus.tx_valid_o && bus.tx_ready_i) begin
      sent_q.push_back(bus.tx_data_o);
      if (mode == 1) core_q.push_back(bus.tx_data_o);
    end
  end

  task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [3:0] sel,
                         input logic [31:0] wdata, output logic [31:0] rdata);
    logic [31:0] r;
    int waited;
    r = $urandom;
    waited = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = {r[31:5], idx, r[1:0]};
    bus.wbs_dat_i = wdata;
    do begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end while (!bus.wbs_ack_o && waited < 8);
    if (!bus.wbs_ack_o) check_eq("ack_timeout", 32'(bus.wbs_ack_o), 32'd1);
    rdata = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic [31:0] dummy;
    wb_xfer(1'b1, idx, sel, d, dummy);
  endtask

  task automatic wb_read(input logic [2:0] idx, output logic [31:0] d);
    wb_xfer(1'b0, idx, 4'hF, $urandom, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] rd, st;
  logic [31:0] ov_w[9];
  int          got, guard, n;
  time         e_flush;

  initial begin
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    bus.tx_ready_i = 0; bus.rx_valid_i = 0; bus.rx_data_i = 0;
    rst_n = 1'b0;
    idle(3);
    check_eq("rst_ack", 32'(bus.wbs_ack_o), 0);
    check_eq("rst_dat", bus.wbs_dat_o, 0);
    check_eq("rst_tx_valid", 32'(bus.tx_valid_o), 0);
    check_eq("rst_rx_ready", 32'(bus.rx_ready_o), 0);
    check_eq("rst_irq", 32'(bus.irq_o), 0);
    rst_n = 1'b1;
    idle(2);
    wb_read(0, rd);
    check_eq("idle_ctrl", rd, 32'h0);
    wb_read(1, rd);
    check_eq("idle_status", rd, 32'h0002_0000);
    check_eq("idle_irq", 32'(bus.irq_o), 0);
    check_eq("idle_tx_valid", 32'(bus.tx_valid_o), 0);
    idle(1);
    check_eq("dat_zero_no_ack", bus.wbs_dat_o, 0);

    // Loopback through an echoing core
    core_q.delete();
    cap_q.delete();
    wb_write(0, 32'h3);
    irq_watch = 1;
    mode = 1;
    for (int i = 0; i < 8; i++) wb_write(2, 32'hA5A5_0001 + i);
    got = 0;
    guard = 0;
    while (got < 8 && guard < 500) begin
      wb_read(1, st);
      if (st[15:8] != 0) begin
        wb_read(3, rd);
        check_eq("loop_word", rd, 32'hA5A5_0001 + 32'(got));
        got++;
      end
      guard++;
    end
    check_eq("loop_count", 32'(got), 32'd8);
    mode = 0;
    idle(2);
    wb_read(1, rd);
    check_eq("loop_status", rd, 32'h0002_0000);
    check_eq("loop_irq_low", 32'(bus.irq_o), 0);

    // Overflow with the streams disabled
    wb_write(0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      ov_w[i] = $urandom;
      wb_write(2, ov_w[i]);
    end
    wb_read(1, rd);
    check_eq("ovf_status", rd, 32'h0007_0008);
    check_eq("ovf_head", bus.tx_data_o, ov_w[0]);
    check_eq("ovf_tx_valid_disabled", 32'(bus.tx_valid_o), 0);
    wb_write(1, 32'h0004_0000, 4'b1011);
    wb_read(1, rd);
    check_eq("ovf_w1c_nosel", rd, 32'h0007_0008);
    wb_write(1, 32'h0004_0000, 4'b0100);
    wb_read(1, rd);
    check_eq("ovf_w1c", rd, 32'h0003_0008);
    sent_q.delete();
    mode = 2;
    wb_write(0, 32'h1);
    for (int i = 0; i < 100 && bus.tx_valid_o; i++) @(negedge clk);
    idle(3);
    check_eq("ovf_drained", 32'(bus.tx_valid_o), 0);
    check_eq("ovf_sent_count", 32'(sent_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < sent_q.size(); i++) check_eq("ovf_sent_word", sent_q[i], ov_w[i]);
    mode = 0;

    // Underflow raises udf and the interrupt
    wb_write(0, 32'h3);
    wb_read(3, rd);
    check_eq("udf_data", rd, 32'h0);
    check_eq("udf_irq", 32'(bus.irq_o), 1);
    wb_read(1, rd);
    check_eq("udf_status", rd, 32'h000A_0000);
    wb_write(1, 32'h0008_0000, 4'b0100);
    check_eq("udf_irq_cleared", 32'(bus.irq_o), 0);
    wb_read(1, rd);
    check_eq("udf_w1c", rd, 32'h0002_0000);

    // Output FIFO backpressure
    wb_write(0, 32'h1);
    cap_q.delete();
    mode = 3;
    for (int i = 0; i < 50 && bus.rx_ready_o; i++) @(negedge clk);
    check_eq("bp_ready_low", 32'(bus.rx_ready_o), 0);
    wb_read(1, rd);
    check_eq("bp_status_full", rd, 32'h0000_0800);
    wb_read(3, rd);
    check_eq("bp_first_word", rd, (cap_q.size() > 0) ? cap_q[0] : 32'hDEAD_BEEF);
    check_eq("bp_ready_back", 32'(bus.rx_ready_o), 1);
    idle(5);
    check_eq("bp_one_more", 32'(cap_q.size()), 32'd9);
    check_eq("bp_ready_low_again", 32'(bus.rx_ready_o), 0);
    mode = 0;
    for (int i = 1; i < 9; i++) begin
      wb_read(3, rd);
      check_eq("bp_word", rd, (i < cap_q.size()) ? cap_q[i] : 32'hDEAD_BEEF);
    end
    wb_read(1, rd);
    check_eq("bp_status_end", rd, 32'h0002_0000);

    // Flush with both FIFOs holding words and the rx stream active
    wb_write(0, 32'h0);
    wb_read(3, rd);
    for (int i = 0; i < 3; i++) wb_write(2, $urandom);
    wb_write(0, 32'h1);
    cap_q.delete();
    cap_t.delete();
    mode = 3;
    idle(3);
    wb_write(0, 32'h5);
    e_flush = $time - 5;
    check_eq("flush_tx_valid", 32'(bus.tx_valid_o), 0);
    mode = 0;
    idle(3);
    n = 0;
    foreach (cap_t[i]) if (cap_t[i] > e_flush) n++;
    wb_read(0, rd);
    check_eq("flush_ctrl", rd, 32'h1);
    wb_read(1, rd);
    check_eq("flush_status", rd,
             32'h0008_0000 | (n == 0 ? 32'h0002_0000 : 32'h0) | (32'(n) << 8));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
